bram_rd_stream: RTL and testbench

Read-side streamer that drains a contiguous address range out of a single-port scratchpad (`bram_sp` read port, 1-cycle registered read latency) and presents it as a valid/ready word stream to the GEMM datapath. A 4-entry output FIFO with credit-based read issue absorbs the BRAM latency under backpressure without dropping or duplicating words. It sits directly downstream of the scratchpad and upstream of the GEMM operand consumers.

---
 rtl/bram_rd_stream.sv | 171 +++++++++++++++++
 tb/tb_bram_rd_stream.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_rd_stream.sv
// Streams a contiguous scratchpad address range out as a valid/ready word stream.
// A 4-entry FIFO with credit-gated read issue absorbs the 1-cycle BRAM read latency.
module bram_rd_stream #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned ADDR  = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR-1:0]   cmd_base_i,
  input  logic [ADDR:0]     cmd_len_i,
  output logic              mem_en_o,
  output logic [ADDR-1:0]   mem_addr_o,
  input  logic [WIDTH-1:0]  mem_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_data_o,
  output logic              out_last_o,
  output logic              done_o
);

  localparam int unsigned LW    = ADDR + 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR-1:0]   base_q, base_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     issued_q, issued_d;
  logic [LW-1:0]     rem_q, rem_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]  fifo_q [DEPTH];
  logic [WIDTH-1:0]  fifo_d [DEPTH];
  logic              inflight_q, inflight_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR-1:0]   mem_addr_q, mem_addr_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;

  logic accept, pop, push;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      rem_q       <= '0;
      occ_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_q      <= '{default: '0};
      inflight_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      cmd_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      rem_q       <= rem_d;
      occ_q       <= occ_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_q      <= fifo_d;
      inflight_q  <= inflight_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      cmd_ready_q <= cmd_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign accept = cmd_ready_q && cmd_valid_i;
  assign pop    = out_valid_q && out_ready_i;
  assign push   = inflight_q;

  // Next-state logic; mem_en is decided one cycle ahead so the port is a flop
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    rem_d      = rem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_d     = fifo_q;
    inflight_d = mem_en_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;

    if (push) begin
      fifo_d[wr_ptr_q] = mem_rdata_i;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      rem_d    = rem_q - LW'(1);
    end
    occ_d = occ_q + CW'(push) - CW'(pop);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          base_d   = cmd_base_i;
          len_d    = cmd_len_i;
          rem_d    = cmd_len_i;
          issued_d = '0;
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = RUN;
            mem_en_d   = 1'b1;
            mem_addr_d = cmd_base_i;
            issued_d   = LW'(1);
          end
        end
      end
      RUN: begin
        // issued_q already counts the read presented this cycle
        if (issued_q == len_q) begin
          state_d = DRAIN;
        end else if ((4'(occ_d) + 4'(mem_en_q)) <= 4'd3) begin
          mem_en_d   = 1'b1;
          mem_addr_d = base_q + issued_q[ADDR-1:0];
          issued_d   = issued_q + LW'(1);
        end
      end
      DRAIN: begin
        if (pop && rem_q == LW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    out_valid_d = (occ_d != '0);
    out_data_d  = fifo_d[rd_ptr_d];
    out_last_d  = out_valid_d && (rem_d == LW'(1));
  end

  assign cmd_ready_o = cmd_ready_q;
  assign mem_en_o    = mem_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_bram_rd_stream.sv
// Scoreboard bench for bram_rd_stream: stimulus pushes expected addresses, words and done
// pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_bram_rd_stream;
  localparam int unsigned WIDTH = 128;
  localparam int unsigned ADDR  = 10;
  localparam int          MSZ   = 1 << ADDR;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready;
  logic [ADDR-1:0]   cmd_base;
  logic [ADDR:0]     cmd_len;
  logic              mem_en;
  logic [ADDR-1:0]   mem_addr;
  logic [WIDTH-1:0]  mem_rdata;
  logic              out_valid, out_ready, out_last, done;
  logic [WIDTH-1:0]  out_data;

  logic [WIDTH-1:0]  mem [MSZ];

  typedef struct { logic [WIDTH-1:0] data; logic last; int cyc; } exp_t;
  exp_t exp_q[$];
  int   exp_addr_q[$];
  int   exp_done_q[$];

  int checks = 0, failures = 0, cyc = 0;
  int en_count = 0, done_count = 0;
  logic             hold_pending = 1'b0;
  logic [WIDTH-1:0] hold_data;
  logic             hold_last;

  bram_rd_stream #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_last_o(out_last), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  function automatic logic [WIDTH-1:0] word_of(input int a);
    if (a >= 16 && a <= 19) return WIDTH'(32'hA0 + 32'(a - 16));
    return {32'hC0DE_0000 + 32'(a), 32'(a * 7 + 1), ~32'(a), 32'(a)};
  endfunction

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: mem reads, stream words, hold stability and done pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (mem_en) begin
        en_count++;
        chk("mem_en_while_idle", WIDTH'(cmd_ready), '0);
        if (exp_addr_q.size() == 0) fail_now("unexpected_mem_en");
        else chk("mem_addr", WIDTH'(mem_addr), WIDTH'(exp_addr_q.pop_front()));
      end
      if (hold_pending) begin
        chk("hold_valid", WIDTH'(out_valid), WIDTH'(1));
        chk("hold_data", out_data, hold_data);
        chk("hold_last", WIDTH'(out_last), WIDTH'(hold_last));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_valid");
        else if (out_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", WIDTH'(out_last), WIDTH'(e.last));
          if (e.cyc >= 0) chk("word_cycle", WIDTH'(cyc), WIDTH'(e.cyc));
        end
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_last    = out_last;
      if (done) begin
        done_count++;
        if (exp_done_q.size() == 0) fail_now("unexpected_done");
        else begin
          int dc;
          dc = exp_done_q.pop_front();
          if (dc >= 0) chk("done_cycle", WIDTH'(cyc), WIDTH'(dc));
        end
      end
    end
  end

  // Offer a command, wait for acceptance, and queue its expected reads, words and done
  task automatic send(input int base, input int len, input bit timed);
    int waited = 0;
    int acc;
    cmd_base  = ADDR'(base);
    cmd_len   = (ADDR + 1)'(len);
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      fail_now("cmd_accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    for (int i = 0; i < len; i++) begin
      int a;
      a = (base + i) % MSZ;
      exp_addr_q.push_back(a);
      exp_q.push_back('{word_of(a), (i == len - 1), (timed ? acc + 3 + i : -1)});
    end
    exp_done_q.push_back(timed ? (len == 0 ? acc + 1 : acc + len + 3) : -1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && n < 3000) begin
      n++;
      @(posedge clk);
    end
    if (exp_q.size() != 0 || exp_done_q.size() != 0) fail_now("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, WIDTH'(cmd_ready), WIDTH'(1));
    chk({tag, "_mem_en"},    WIDTH'(mem_en),    '0);
    chk({tag, "_mem_addr"},  WIDTH'(mem_addr),  '0);
    chk({tag, "_out_valid"}, WIDTH'(out_valid), '0);
    chk({tag, "_out_data"},  out_data,          '0);
    chk({tag, "_out_last"},  WIDTH'(out_last),  '0);
    chk({tag, "_done"},      WIDTH'(done),      '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, dc0;
    for (int a = 0; a < MSZ; a++) mem[a] = word_of(a);
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; out_ready = 1'b1;
    #12;
    chk_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Basic stream with fixed latency
    en0 = en_count;
    send(16, 4, 1'b1);
    wait_idle();
    chk("basic_en_count", WIDTH'(en_count - en0), WIDTH'(4));

    // Backpressure from accept: 4 reads, head held, then drained
    out_ready = 1'b0;
    en0 = en_count;
    send(16, 4, 1'b0);
    repeat (9) @(posedge clk); #1;
    chk("bp_en_count", WIDTH'(en_count - en0), WIDTH'(4));
    chk("bp_head", out_data, 128'hA0);
    out_ready = 1'b1;
    wait_idle();

    // Credit cap: longer command stalls after 4 outstanding reads
    out_ready = 1'b0;
    en0 = en_count;
    send(64, 8, 1'b0);
    repeat (9) @(posedge clk); #1;
    chk("credit_cap", WIDTH'(en_count - en0), WIDTH'(4));
    out_ready = 1'b1;
    wait_idle();
    chk("credit_total", WIDTH'(en_count - en0), WIDTH'(8));

    // Zero-length command
    en0 = en_count; dc0 = done_count;
    send(85, 0, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("len0_en", WIDTH'(en_count - en0), '0);
    chk("len0_done", WIDTH'(done_count - dc0), WIDTH'(1));

    // Address wrap
    send(1022, 4, 1'b1);
    wait_idle();

    // Back-to-back commands under random backpressure
    dc0 = done_count;
    fork
      begin
        send(256, 3, 1'b0);
        send(300, 2, 1'b0);
        chk("b2b_first_done", WIDTH'(done_count - dc0), WIDTH'(1));
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("b2b_done_count", WIDTH'(done_count - dc0), WIDTH'(2));

    // Full address space
    en0 = en_count;
    send(512, 1024, 1'b1);
    wait_idle();
    chk("full_en_count", WIDTH'(en_count - en0), WIDTH'(1024));

    // Reset during DRAIN with two words buffered
    out_ready = 1'b0;
    send(128, 2, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("pre_reset_valid", WIDTH'(out_valid), WIDTH'(1));
    rst_n = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    exp_done_q.delete();
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(16, 4, 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
